cmp_scan_ctrl: RTL and testbench



---
 rtl/cmp_scan_ctrl.sv | 162 ++++++++++++++++
 tb/tb_cmp_scan_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cmp_scan_ctrl.sv
// +----------------------------------------------------------------------------+
// | cmp_scan_ctrl : load buffer, shared-comparator max/min scan, live query    |
// | Optional: CMP_SCAN_MIN_EN adds the MIN phase (two comparator uses/element) |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module cmp_scan_ctrl #(
  parameter int DEPTH = 8,
  parameter int W     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W-1:0]             sw,
  input  logic                     load,
  input  logic                     start,
  input  logic                     clear,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     busy,
  output logic                     done,
  output logic [W-1:0]             max,
  output logic [W-1:0]             min,
  output logic [2:0]               led,
  output logic [6:0]               sled
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [6:0] SEG_LESS  = 7'b1110001;
  localparam logic [6:0] SEG_GREAT = 7'b0100001;
  localparam logic [6:0] SEG_EQUAL = 7'b0110000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_idx;
  logic [W-1:0]  r_buf [DEPTH];
`ifdef CMP_SCAN_MIN_EN
  logic          r_phase_n;
`endif

  logic [W-1:0]  w_cmp_a;
  logic [W-1:0]  w_cmp_b;
  logic          w_gt;
  logic          w_lt;
  logic          w_wr;
  logic          w_go;
  logic          w_last;

  // Single comparator: scan engine owns it in SCAN, query path otherwise.
  always_comb begin
    w_cmp_a = sw;
    w_cmp_b = max;
    if (r_state == S_SCAN) begin
      w_cmp_a = r_buf[r_idx];
`ifdef CMP_SCAN_MIN_EN
      w_cmp_b = r_phase_n ? min : max;
`endif
    end
  end

  assign w_gt   = (w_cmp_a > w_cmp_b);
  assign w_lt   = (w_cmp_a < w_cmp_b);
  assign full   = (count == CW'(DEPTH));
  assign busy   = (r_state == S_SCAN);
  assign done   = (r_state == S_DONE);
  assign w_last = ({1'b0, r_idx} == (count - CW'(1)));

  // Priority CLEAR > LOAD > START is folded into these qualifiers.
  assign w_wr = load & ~clear & ~full & (r_state == S_IDLE);
  assign w_go = start & ~clear & ~load & (r_state != S_SCAN) & (count != '0);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_buf[count[AW-1:0]] <= sw;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      count     <= '0;
      max       <= '0;
      min       <= '0;
      led       <= 3'b000;
      sled      <= SEG_BLANK;
      r_idx     <= '0;
`ifdef CMP_SCAN_MIN_EN
      r_phase_n <= 1'b0;
`endif
    end else if (clear) begin
      r_state   <= S_IDLE;
      count     <= '0;
      max       <= '0;
      min       <= '0;
      led       <= 3'b000;
      sled      <= SEG_BLANK;
      r_idx     <= '0;
`ifdef CMP_SCAN_MIN_EN
      r_phase_n <= 1'b0;
`endif
    end else begin
      if (w_wr) begin
        count <= count + CW'(1);
      end
      if (w_go) begin
        max   <= r_buf[0];
`ifdef CMP_SCAN_MIN_EN
        min       <= r_buf[0];
        r_phase_n <= 1'b0;
`endif
        r_idx   <= AW'(1);
        led     <= 3'b000;
        sled    <= SEG_BLANK;
        r_state <= (count == CW'(1)) ? S_DONE : S_SCAN;
      end else begin
        case (r_state)
          S_SCAN: begin
`ifdef CMP_SCAN_MIN_EN
            if (!r_phase_n) begin
              if (w_gt) max <= w_cmp_a;
              r_phase_n <= 1'b1;
            end else begin
              if (w_lt) min <= w_cmp_a;
              r_phase_n <= 1'b0;
              if (w_last) r_state <= S_DONE;
              else        r_idx   <= r_idx + AW'(1);
            end
`else
            if (w_gt) max <= w_cmp_a;
            if (w_last) r_state <= S_DONE;
            else        r_idx   <= r_idx + AW'(1);
`endif
          end
          S_DONE: begin
            if (w_gt) begin
              led  <= 3'b100;
              sled <= SEG_GREAT;
            end else if (w_lt) begin
              led  <= 3'b001;
              sled <= SEG_LESS;
            end else begin
              led  <= 3'b010;
              sled <= SEG_EQUAL;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cmp_scan_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_cmp_scan_ctrl : directed self-checking bench for cmp_scan_ctrl          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cmp_scan_ctrl;

  localparam int DEPTH = 8;
  localparam int W     = 4;
`ifdef CMP_SCAN_MIN_EN
  localparam int PH    = 2;
  localparam bit MINEN = 1'b1;
`else
  localparam int PH    = 1;
  localparam bit MINEN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sw = '0;
  logic         load = 1'b0;
  logic         start = 1'b0;
  logic         clear = 1'b0;
  logic [3:0]   count;
  logic         full;
  logic         busy;
  logic         done;
  logic [W-1:0] max;
  logic [W-1:0] min;
  logic [2:0]   led;
  logic [6:0]   sled;

  int checks   = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  cmp_scan_ctrl #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst(rst), .sw(sw), .load(load), .start(start), .clear(clear),
    .count(count), .full(full), .busy(busy), .done(done),
    .max(max), .min(min), .led(led), .sled(sled)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_val(input logic [W-1:0] v);
    sw   = v;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts cycles with BUSY high, bounded so a stuck scan still terminates.
  task automatic run_scan(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      tick();
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_count", count, 0);
    check("rst_full",  full, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_max",   max, 0);
    check("rst_min",   min, 0);
    check("rst_led",   led, 3'b000);
    check("rst_sled",  sled, 7'b1111111);

    load_val(4'd3);
    check("load1_count", count, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_count", count, 0);

    // Main scan: 5, 9, 2, 9, 0
    load_val(4'd5); load_val(4'd9); load_val(4'd2); load_val(4'd9); load_val(4'd0);
    check("load5_count", count, 5);
    pulse_start();
    check("scan_busy0", busy, 1);
    check("scan_max0",  max, 5);
    check("scan_min0",  min, MINEN ? 5 : 0);
    run_scan(n);
    check("scan_cycles", n, 4 * PH);
    check("scan_done",   done, 1);
    check("scan_max",    max, 9);
    check("scan_min",    min, 0);
    check("done_led0",   led, 3'b000);

    sw = 4'd4;
    tick();
    check("q_lt_led",  led, 3'b001);
    check("q_lt_sled", sled, 7'b1110001);
    sw = 4'd9;
    tick();
    check("q_eq_led",  led, 3'b010);
    check("q_eq_sled", sled, 7'b0110000);
    sw = 4'd12;
    tick();
    check("q_gt_led",  led, 3'b100);
    check("q_gt_sled", sled, 7'b0100001);

    // Rescan from DONE, then asynchronous reset mid-scan
    pulse_start();
    check("rescan_busy", busy, 1);
    check("rescan_led",  led, 3'b000);
    #3 rst = 1'b1;
    #1;
    check("arst_count", count, 0);
    check("arst_busy",  busy, 0);
    check("arst_max",   max, 0);
    check("arst_sled",  sled, 7'b1111111);
    #1 rst = 1'b0;
    tick();

    // Buffer limits: ninth load (15) must be dropped
    for (int i = 1; i <= 8; i++) load_val(4'(i));
    load_val(4'd15);
    check("full_count", count, 8);
    check("full_flag",  full, 1);
    pulse_start();
    run_scan(n);
    check("full_cycles", n, 7 * PH);
    check("full_max",    max, 8);
    check("full_min",    min, MINEN ? 1 : 0);

    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    check("clrstart_done",  done, 0);
    check("clrstart_busy",  busy, 0);
    check("clrstart_count", count, 0);
    check("clrstart_max",   max, 0);

    pulse_start();
    check("start0_busy", busy, 0);
    check("start0_done", done, 0);

    load_val(4'd7);
    pulse_start();
    check("single_done", done, 1);
    check("single_busy", busy, 0);
    check("single_max",  max, 7);
    check("single_min",  min, MINEN ? 7 : 0);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    sw    = 4'd6;
    load  = 1'b1;
    start = 1'b1;
    tick();
    load  = 1'b0;
    start = 1'b0;
    check("ldst_count", count, 1);
    check("ldst_busy",  busy, 0);
    check("ldst_done",  done, 0);

    // Clear in the third scan cycle
    load_val(4'd3); load_val(4'd10); load_val(4'd1); load_val(4'd14);
    pulse_start();
    tick();
    tick();
    check("abort_busy_pre", busy, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("abort_busy",  busy, 0);
    check("abort_done",  done, 0);
    check("abort_count", count, 0);
    check("abort_max",   max, 0);
    check("abort_min",   min, 0);
    load_val(4'd5);
    pulse_start();
    check("abort_buf0", max, 5);
    check("abort_dn",   done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
